// File: rtl/zoom2x_frame_sequencer.sv
// zoom2x_frame_sequencer
// Frame-level controller for the 2x pixel-replication zoom path. Walks the
// source image in raster order, reads one 8-bit pixel per step and writes it
// to the four destination addresses of its 2x2 block.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start; all outputs low
// READ  | one-cycle source read strobe at y*SRC_W + x
// WAIT  | source data returns; latch it into r_pix, reset block index k
// WRITE | present r_pix at block position k, advance k on each accepted write
// DONE  | one-cycle done pulse, then back to IDLE
module zoom2x_frame_sequencer #(
  parameter int SRC_W      = 160,
  parameter int SRC_H      = 120,
  parameter int SRC_ADDR_W = 15,
  parameter int DST_ADDR_W = 17
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_src_rd_en,
  output logic [SRC_ADDR_W-1:0] o_src_addr,
  input  logic [7:0]            i_src_data,
  output logic                  o_dst_wr_en,
  output logic [DST_ADDR_W-1:0] o_dst_addr,
  output logic [7:0]            o_dst_data,
  input  logic                  i_dst_ready
);

  localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [1:0]      r_k;
  logic [7:0]      r_pix;

  logic                  w_accept;
  logic                  w_x_wrap;
  logic                  w_last;
  logic [SRC_ADDR_W-1:0] w_src_addr;
  logic [DST_ADDR_W-1:0] w_dst_addr;

  assign w_accept = (r_state == WRITE) && i_dst_ready;
  assign w_x_wrap = (r_x == XW'(SRC_W - 1));
  assign w_last   = w_x_wrap && (r_y == YW'(SRC_H - 1));

  // Address products are formed at 32 bits and truncated to the port widths.
  assign w_src_addr = SRC_ADDR_W'(32'(r_y) * 32'(SRC_W) + 32'(r_x));
  assign w_dst_addr = DST_ADDR_W'((32'(r_y) * 32'd2 + 32'(r_k[1])) * (32'd2 * 32'(SRC_W))
                                  + 32'(r_x) * 32'd2 + 32'(r_k[0]));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; unknown encodings fall back to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = READ;
      READ:    w_next = WAIT;
      WAIT:    w_next = WRITE;
      WRITE: begin
        if (w_accept && (r_k == 2'd3)) begin
          w_next = w_last ? DONE : READ;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Raster position, block index and latched pixel.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_k   <= '0;
      r_pix <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_x <= '0;
            r_y <= '0;
            r_k <= '0;
          end
        end
        WAIT: begin
          r_pix <= i_src_data;
          r_k   <= '0;
        end
        WRITE: begin
          if (w_accept) begin
            if (r_k == 2'd3) begin
              r_k <= '0;
              if (!w_last) begin
                if (w_x_wrap) begin
                  r_x <= '0;
                  r_y <= r_y + YW'(1);
                end else begin
                  r_x <= r_x + XW'(1);
                end
              end
            end else begin
              r_k <= r_k + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs; address/data buses are forced to zero outside their state.
  always_comb begin
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_src_rd_en = 1'b0;
    o_src_addr  = '0;
    o_dst_wr_en = 1'b0;
    o_dst_addr  = '0;
    o_dst_data  = '0;
    case (r_state)
      READ: begin
        o_busy      = 1'b1;
        o_src_rd_en = 1'b1;
        o_src_addr  = w_src_addr;
      end
      WAIT: begin
        o_busy = 1'b1;
      end
      WRITE: begin
        o_busy      = 1'b1;
        o_dst_wr_en = 1'b1;
        o_dst_addr  = w_dst_addr;
        o_dst_data  = r_pix;
      end
      DONE: begin
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
